p521_modred: RTL and testbench

- Iterative, word-serial modular reduction stage that sits directly downstream of the 521x521 schoolbook multiplier.
- Consumes the 2N-bit product and returns the product mod p = 2^N - 1 (the P-521 Mersenne prime when N=521), using the identity 2^N ≡ 1 (mod p).
- Narrow W-bit datapath over multiple cycles, matching the area-lean, multi-cycle style of the multiplier.

---
 rtl/p521_modred.sv | 148 ++++++++++++++
 tb/tb_p521_modred.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p521_modred.sv
// p521_modred: word-serial reduction of a 2N-bit product mod p = 2^N - 1.
// Define P521_MODRED_CANON_EN to map the all-ones residue to 0 on output.
module p521_modred #(
  parameter int N = 521,
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] prod,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   r
);

  localparam int K  = (N + W - 1) / W;
  localparam int KW = K * W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam logic [KW-1:0] MASK = KW'({N{1'b1}});

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_FOLD = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] lo_q, lo_d;
  logic [KW-1:0] hi_q, hi_d;
  logic [KW-1:0] s_q, s_d;
  logic [N-1:0]  r_q, r_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [KW-1:0] s_m;
  logic          s_top;
  logic [W-1:0]  a_c;
  logic [W-1:0]  b_c;
  logic          cin;
  logic [W:0]    sum;
  logic [N-1:0]  t;
  logic [N-1:0]  r_fin;
  int            idx;

  // s[N] sits in the padded top chunk, or in the final carry if N fills it.
  if (N < KW) begin : g_pad
    assign s_top = s_q[N];
  end else begin : g_nopad
    assign s_top = carry_q;
  end

  assign s_m = s_q & MASK;
  assign t   = s_q[N-1:0];

`ifdef P521_MODRED_CANON_EN
  assign r_fin = (&t) ? '0 : t;
`else
  assign r_fin = t;
`endif

  always_comb begin
    idx = int'(cnt_q) * W;
    a_c = lo_q[idx +: W];
    b_c = hi_q[idx +: W];
    cin = carry_q;
    if (state_q == S_FOLD) begin
      a_c = s_m[idx +: W];
      b_c = '0;
      cin = (cnt_q == '0) ? s_top : carry_q;
    end
    sum = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, cin};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    s_d     = s_q;
    r_d     = r_q;
    done_d  = done_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          lo_d    = KW'(prod[N-1:0]);
          hi_d    = KW'(prod[2*N-1:N]);
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD, S_FOLD: begin
        // FOLD rewrites s in place; s[N] is only read at chunk 0
        s_d[idx +: W] = sum[W-1:0];
        carry_d       = sum[W];
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = (state_q == S_ADD) ? S_FOLD : S_FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        r_d     = r_fin;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      s_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;

endmodule

// File: tb/tb_p521_modred.sv
// tb_p521_modred: random and directed checks of p521_modred against
// a modulo-arithmetic reference with a fixed-latency timing model.
module tb_p521_modred;

  localparam int N   = 521;
  localparam int K   = 9;
  localparam int LAT = 2 * K + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] prod;
  logic           busy;
  logic           done;
  logic [N-1:0]   r;

  always #5 clk = ~clk;

  p521_modred #(.N(N), .W(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .prod  (prod),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Residue of x; the lazy build may return p instead of 0 unless x == 0.
  function automatic logic [N-1:0] modref(input logic [2*N-1:0] x);
    logic [2*N:0] xw;
    logic [2*N:0] pw;
    logic [2*N:0] m;
    xw = {1'b0, x};
    pw = {{(N+1){1'b0}}, {N{1'b1}}};
    m  = xw % pw;
`ifndef P521_MODRED_CANON_EN
    if (m == '0 && x != '0) return {N{1'b1}};
`endif
    return m[N-1:0];
  endfunction

  function automatic logic [2*N-1:0] rnd();
    logic [33*32-1:0] w;
    logic [2*N-1:0]   v;
    int               mode;
    for (int i = 0; i < 33; i++) w[i*32 +: 32] = $urandom;
    v    = w[2*N-1:0];
    mode = $urandom_range(0, 7);
    if (mode == 0) v = '1;
    else if (mode == 1) v[2*N-1:N] = '1;
    else if (mode == 2) v[2*N-1:64] = '0;
    else if (mode == 3) v[N-1:0] = '1;
    return v;
  endfunction

  // Timing model: result appears LAT edges after acceptance.
  logic         m_busy;
  logic         m_done;
  logic [N-1:0] m_r;
  logic [N-1:0] m_res;
  int           m_left;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_r    = '0;
      m_left = 0;
      chk_en = 1'b1;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      if (start) begin
        m_res  = modref(prod);
        m_left = LAT;
        m_busy = 1'b1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_r    = m_res;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", N'(busy), N'(m_busy));
      check("cyc_done", N'(done), N'(m_done));
      check("cyc_r", r, m_r);
    end
  end

  task automatic run_op(input logic [2*N-1:0] p, output logic [N-1:0] rv,
                        output int lat);
    start = 1'b1;
    prod  = p;
    @(negedge clk);
    start = 1'b0;
    prod  = ~p;
    lat   = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    rv = r;
  endtask

  logic [N-1:0]   rv;
  logic [N-1:0]   pm;
  logic [N-1:0]   ones_exp;
  logic [N-1:0]   pow_exp;
  logic [2*N-1:0] v_ones;
  logic [2*N-1:0] v_sq;
  logic [2*N-1:0] v_pow;
  int             lat;
  int             ndone;

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    prod  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", N'(busy), '0);
    check("rst_done", N'(done), '0);
    check("rst_r", r, '0);
    rst = 1'b1;

    pm     = {N{1'b1}};
    v_ones = '1;
    v_sq   = {{N{1'b0}}, pm - N'(1)};
    v_sq   = v_sq * v_sq;
    v_pow  = '0;
    v_pow[2*N-1] = 1'b1;
    pow_exp      = '0;
    pow_exp[N-1] = 1'b1;
`ifdef P521_MODRED_CANON_EN
    ones_exp = '0;
`else
    ones_exp = pm;
`endif
    check("mdl_ones", modref(v_ones), ones_exp);
    check("mdl_sq", modref(v_sq), N'(1));
    check("mdl_pow", modref(v_pow), pow_exp);
    check("mdl_zero", modref('0), '0);

    @(negedge clk);
    run_op('0, rv, lat);
    check("zero_lat", N'(lat), N'(LAT));
    check("zero_r", rv, '0);
    run_op(v_ones, rv, lat);
    check("ones_r", rv, ones_exp);
    run_op(v_sq, rv, lat);
    check("sq_r", rv, N'(1));
    run_op(v_pow, rv, lat);
    check("pow_r", rv, pow_exp);

    // starts while busy or in FIN must be dropped
    start = 1'b1;
    prod  = (2*N)'(5);
    ndone = 0;
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      if (done) ndone++;
      start = (j == 3 || j == 18 || j == 19);
      prod  = (2*N)'(7);
    end
    @(negedge clk);
    check("ign_done", N'(done), N'(1));
    check("ign_early", N'(ndone), '0);
    check("ign_r", r, N'(5));
    start = 1'b1;
    prod  = (2*N)'(9);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check("b2b_lat", N'(lat), N'(LAT));
    check("b2b_r", r, N'(9));

    // reset in the middle of an operation
    start = 1'b1;
    prod  = rnd();
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_r", r, '0);
    check("abort_busy", N'(busy), '0);
    check("abort_done", N'(done), '0);
    rst   = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_nodone", N'(ndone), '0);
    run_op((2*N)'(3), rv, lat);
    check("post_lat", N'(lat), N'(LAT));
    check("post_r", rv, N'(3));

    // back-to-back random traffic, start held high
    ndone = 0;
    start = 1'b1;
    for (int c = 0; c < 1000 * (LAT + 1) + 50 && ndone < 1000; c++) begin
      prod = rnd();
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check("rand_count", N'(ndone), N'(1000));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
